instr_issue: RTL and testbench
==============================

// Module: instr_issue
// PURPOSE
//  Instruction issue unit; producer side of the control-FSM handshake. Buffers 16-bit
//  instructions from the program loader in a small FIFO, presents the head word on
//  instr with a new_instr request while the control FSM idles in s0, and holds it
//  stable until the FSM returns to s0. Retires each instruction with a done pulse;
//  flags illegal opcodes and hung executions.
// PARAMETERS
//  DEPTH      4   FIFO entries (power of 2, >=2)
//  WDOG_MAX   8   max cycles in EXEC before wdog_err (longest legal op = 5)
// PORTS
//  clock       in   1   rising-edge clock
//  resetn      in   1   asynchronous active-low reset
//  din         in   16  instruction word from loader
//  din_valid   in   1   din present
//  din_ready   out  1   FIFO not full; write when din_valid & din_ready
//  hold        in   1   single-step hold: no new issue while 1
//  state       in   4   current control-FSM state (s0 = 4'b0000, s1 = 4'b0001)
//  new_instr   out  1   issue request to control FSM
//  instr       out  16  instruction to control FSM / datapath
//  done        out  1   1-cycle pulse on retire
//  illegal_op  out  1   1-cycle pulse with done when retired opcode instr[15:13]==3'b111
//  wdog_err    out  1   sticky; cleared only by reset
//  busy        out  1   1 while in REQ or EXEC
// BEHAVIOUR
//  Reset (async, resetn=0): FIFO empty, FSM IDLE, new_instr=0, instr=16'h0000, done=0,
//   illegal_op=0, wdog_err=0, busy=0, din_ready=1, watchdog count=0.
//   Reset mid-execution discards the in-flight instruction and all queued words.
//  FIFO: write when din_valid & din_ready; pop only on retire. Simultaneous write and
//   pop when full is refused (din_ready reflects full before the pop). Pointers wrap modulo DEPTH.
//  Issue FSM (registered outputs):
//   IDLE: if FIFO non-empty & !hold & state==s0 -> REQ; instr<=head, new_instr<=1.
//   REQ : new_instr held 1, instr stable. When state!=s0 -> EXEC, new_instr<=0.
//         Stays in REQ while state==s0 (FSM not yet sampled); hold ignored once in REQ.
//   EXEC: instr stable. When state==s0 -> retire: done<=1, illegal_op<=(instr[15:13]==3'b111),
//         pop head, -> IDLE. Earliest re-issue is the cycle after done.
//  Latency: empty FIFO + write at cycle 0 -> new_instr=1 at cycle 2 (write, then IDLE issue).
//  Watchdog: counts cycles in EXEC; if count reaches WDOG_MAX with state!=s0, set
//   wdog_err=1 and remain in EXEC (no forced retire). Counter cleared on entering EXEC.
//  Opcode 111 still issued (FSM returns s1->s0); it is only flagged on retire.
//  busy = (issue FSM != IDLE). done/illegal_op are never asserted together with new_instr.
// STRUCTURE
//  Shared package cpu_pkg: OPC_* (3'b000 ld .. 3'b110 br, 3'b111 illegal), ST_S0/ST_S1
//   state codes, INSTR_W=16; the control FSM uses the same constants.
//  Sub-module: instr_fifo (sync FIFO, DEPTH x 16, full/empty, async active-low reset).
//  Top: 3-state issue FSM + watchdog counter + output registers.
// TESTING (bench models control FSM: s0->s1->opcode path->s0, e.g. add = 5 cycles)
//  Reset then din=16'h4123 (add) valid 1 cycle -> new_instr at cycle 2, instr=16'h4123
//   stable until state==s0 after add2; done pulses once; illegal_op=0.
//  Write 5 words back-to-back with model stalled (state held s0, DEPTH=4) -> din_ready=0
//   after 4th; 5th refused; after retiring head din_ready=1; issue order = write order.
//  hold=1 with FIFO non-empty -> new_instr stays 0; release -> REQ next cycle.
//  din=16'hE000 (opcode 111) -> FSM model s1->s0; done and illegal_op pulse together.
//  Model sticks in state 4'b1001 -> wdog_err=1 after WDOG_MAX EXEC cycles, stays 1.
//  resetn=0 during EXEC of add -> all outputs to reset values immediately; FIFO empty.

Source files
------------

// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module   : cpu_pkg
//  Brief    : Opcode, control-FSM state codes and issue-FSM states shared by
//             the instruction issue unit and the control FSM.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int INSTR_W = 16;

    localparam logic [2:0] OPC_LD  = 3'b000;
    localparam logic [2:0] OPC_ST  = 3'b001;
    localparam logic [2:0] OPC_ADD = 3'b010;
    localparam logic [2:0] OPC_SUB = 3'b011;
    localparam logic [2:0] OPC_AND = 3'b100;
    localparam logic [2:0] OPC_OR  = 3'b101;
    localparam logic [2:0] OPC_BR  = 3'b110;
    localparam logic [2:0] OPC_ILL = 3'b111;

    localparam logic [3:0] ST_S0 = 4'b0000;
    localparam logic [3:0] ST_S1 = 4'b0001;

    typedef enum logic [1:0] {
        ISS_IDLE = 2'd0,
        ISS_REQ  = 2'd1,
        ISS_EXEC = 2'd2
    } iss_state_t;

    function automatic logic is_illegal(input logic [INSTR_W-1:0] i_word);
        return i_word[INSTR_W-1 -: 3] == OPC_ILL;
    endfunction

endpackage

`default_nettype wire

// File: rtl/instr_fifo.sv
// ============================================================================
//  Module   : instr_fifo
//  Brief    : Synchronous DEPTH x WIDTH FIFO with full/empty flags.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr;
    logic             w_rd;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_wr      = i_wr_en & ~o_full;
    assign w_rd      = i_rd_en & ~o_empty;
    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            if (w_rd) r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end

endmodule

`default_nettype wire

// File: rtl/instr_issue.sv
// ============================================================================
//  Module   : instr_issue
//  Brief    : Instruction issue unit - buffers loader words and hands them to
//             the control FSM with a new_instr/state handshake; retire, illegal
//             opcode and watchdog reporting.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_issue
    import cpu_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int WDOG_MAX = 8
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [INSTR_W-1:0] din,
    input  logic               din_valid,
    output logic               din_ready,
    input  logic               hold,
    input  logic [3:0]         state,
    output logic               new_instr,
    output logic [INSTR_W-1:0] instr,
    output logic               done,
    output logic               illegal_op,
    output logic               wdog_err,
    output logic               busy
);

    localparam int            CW          = $clog2(WDOG_MAX + 1);
    localparam logic [CW-1:0] C_WDOG_SAT  = CW'(WDOG_MAX);
    localparam logic [CW-1:0] C_WDOG_LAST = CW'(WDOG_MAX - 1);

    iss_state_t         r_state, w_state_nxt;
    logic [INSTR_W-1:0] r_instr, w_instr_nxt;
    logic               r_new_instr, w_new_instr_nxt;
    logic               r_done, w_done_nxt;
    logic               r_illegal, w_illegal_nxt;
    logic               r_wdog, w_wdog_nxt;
    logic [CW-1:0]      r_wdog_cnt, w_wdog_cnt_nxt;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [INSTR_W-1:0] w_head;

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clock     (clock),
        .resetn    (resetn),
        .i_wr_en   (din_valid),
        .i_wr_data (din),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ISS_IDLE;
            r_instr     <= '0;
            r_new_instr <= 1'b0;
            r_done      <= 1'b0;
            r_illegal   <= 1'b0;
            r_wdog      <= 1'b0;
            r_wdog_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_instr     <= w_instr_nxt;
            r_new_instr <= w_new_instr_nxt;
            r_done      <= w_done_nxt;
            r_illegal   <= w_illegal_nxt;
            r_wdog      <= w_wdog_nxt;
            r_wdog_cnt  <= w_wdog_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_instr_nxt     = r_instr;
        w_new_instr_nxt = r_new_instr;
        w_done_nxt      = 1'b0;
        w_illegal_nxt   = 1'b0;
        w_wdog_nxt      = r_wdog;
        w_wdog_cnt_nxt  = r_wdog_cnt;
        w_pop           = 1'b0;
        case (r_state)
            ISS_IDLE: begin
                if (!w_empty && !hold && (state == ST_S0)) begin
                    w_state_nxt     = ISS_REQ;
                    w_instr_nxt     = w_head;
                    w_new_instr_nxt = 1'b1;
                end
            end
            ISS_REQ: begin
                // The control FSM leaving s0 is the acknowledge.
                if (state != ST_S0) begin
                    w_state_nxt     = ISS_EXEC;
                    w_new_instr_nxt = 1'b0;
                    w_wdog_cnt_nxt  = '0;
                end
            end
            ISS_EXEC: begin
                if (state == ST_S0) begin
                    w_state_nxt   = ISS_IDLE;
                    w_done_nxt    = 1'b1;
                    w_illegal_nxt = is_illegal(r_instr);
                    w_pop         = 1'b1;
                end else begin
                    // Watchdog only flags; the instruction stays in flight.
                    if (r_wdog_cnt != C_WDOG_SAT) w_wdog_cnt_nxt = r_wdog_cnt + 1'b1;
                    if (r_wdog_cnt == C_WDOG_LAST) w_wdog_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt     = ISS_IDLE;
                w_new_instr_nxt = 1'b0;
            end
        endcase
    end

    assign din_ready  = ~w_full;
    assign new_instr  = r_new_instr;
    assign instr      = r_instr;
    assign done       = r_done;
    assign illegal_op = r_illegal;
    assign wdog_err   = r_wdog;
    assign busy       = (r_state != ISS_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_instr_issue.sv
// ============================================================================
//  Module   : tb_instr_issue
//  Brief    : Self-checking bench for instr_issue with a control-FSM model and
//             a queue-based reference of loader words in flight.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_issue;
    import cpu_pkg::*;

    localparam int DEPTH    = 4;
    localparam int WDOG_MAX = 8;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] din = '0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic        hold = 1'b0;
    logic [3:0]  state = ST_S0;
    logic        new_instr;
    logic [15:0] instr;
    logic        done;
    logic        illegal_op;
    logic        wdog_err;
    logic        busy;

    always #5 clock = ~clock;

    instr_issue #(.DEPTH(DEPTH), .WDOG_MAX(WDOG_MAX)) dut (
        .clock(clock), .resetn(resetn), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .hold(hold), .state(state), .new_instr(new_instr),
        .instr(instr), .done(done), .illegal_op(illegal_op), .wdog_err(wdog_err),
        .busy(busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: words accepted but not yet retired, head first.
    logic [15:0] q[$];
    bit          m_inflight, m_acked, m_wdog;
    int          m_cnt;
    logic [15:0] m_instr;

    // Control-FSM model knobs.
    int ctrl_left;
    bit stall, stuck;

    typedef struct {
        logic [15:0] word;
        int          issue_t;
        int          done_t;
        bit          ill;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int oplen(input logic [2:0] op);
        case (op)
            3'd0, 3'd1: return 4;
            3'd2, 3'd3: return 5;
            3'd4, 3'd5: return 3;
            3'd6:       return 2;
            default:    return 1;
        endcase
    endfunction

    // One clock: predict from inputs, cross the edge, check at negedge, drive FSM model.
    task automatic tick();
        bit          exp_wr, exp_issue, exp_ack, exp_ret;
        logic [15:0] wd;
        logic [15:0] op_word;
        wd        = din;
        exp_wr    = din_valid && (q.size() < DEPTH);
        exp_issue = !m_inflight && (q.size() > 0) && !hold && (state == ST_S0);
        exp_ack   = m_inflight && !m_acked && (state != ST_S0);
        exp_ret   = m_inflight && m_acked && (state == ST_S0);
        if (m_inflight && m_acked && (state != ST_S0)) begin
            m_cnt++;
            if (m_cnt >= WDOG_MAX) m_wdog = 1'b1;
        end
        @(negedge clock);
        if (exp_ret) begin
            chk("done", done, 1);
            chk("illegal_op", illegal_op, (q[0][15:13] == 3'b111));
            void'(q.pop_front());
            m_inflight = 0;
            m_acked    = 0;
        end else begin
            chk("done_quiet", done, 0);
            chk("illegal_quiet", illegal_op, 0);
        end
        if (exp_wr) q.push_back(wd);
        if (exp_issue) begin
            m_inflight = 1;
            m_acked    = 0;
            m_instr    = q[0];
        end
        if (exp_ack) begin
            m_acked = 1;
            m_cnt   = 0;
        end
        chk("new_instr", new_instr, m_inflight && !m_acked);
        chk("busy", busy, m_inflight);
        chk("instr", instr, m_instr);
        chk("din_ready", din_ready, q.size() < DEPTH);
        chk("wdog_err", wdog_err, m_wdog);
        if (stall) begin
            state = ST_S0;
        end else if (ctrl_left > 0) begin
            state = stuck ? 4'b1001 : 4'b0010;
            if (!stuck) ctrl_left--;
        end else if (new_instr && (state == ST_S0)) begin
            op_word   = instr;
            state     = ST_S1;
            ctrl_left = stuck ? 1 : oplen(op_word[15:13]) - 1;
        end else begin
            state = ST_S0;
        end
    endtask

    task automatic async_reset();
        #2 resetn = 1'b0;
        #1;
        chk("rst_new_instr", new_instr, 0);
        chk("rst_instr", instr, 16'h0000);
        chk("rst_done", done, 0);
        chk("rst_illegal", illegal_op, 0);
        chk("rst_wdog", wdog_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_din_ready", din_ready, 1);
        q.delete();
        m_inflight = 0; m_acked = 0; m_wdog = 0; m_cnt = 0; m_instr = '0;
        ctrl_left = 0; stall = 0; stuck = 0;
        state = ST_S0; din_valid = 1'b0; hold = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        din_valid = 1'b0;
        hold      = 1'b0;
        while ((q.size() > 0 || m_inflight) && n < 300) begin
            tick();
            n++;
        end
        chk(name, busy, 0);
    endtask

    initial begin
        int          t, got_issue, got_done;
        bit          got_ill;
        logic [15:0] issued[$];
        logic [15:0] ww;

        async_reset();

        vecs[0] = '{16'h4123, 2, 8, 1'b0};
        vecs[1] = '{16'hE000, 2, 4, 1'b1};
        vecs[2] = '{16'hC0FF, 2, 5, 1'b0};
        vecs[3] = '{16'h8A5A, 2, 6, 1'b0};

        for (int i = 0; i < 4; i++) begin
            din = vecs[i].word; din_valid = 1'b1;
            t = 0; got_issue = -1; got_done = -1; got_ill = 0;
            while (got_done < 0 && t < 40) begin
                tick();
                t++;
                din_valid = 1'b0;
                if (new_instr && got_issue < 0) begin
                    got_issue = t;
                    chk("vec_instr", instr, vecs[i].word);
                end
                if (done) begin
                    got_done = t;
                    got_ill  = illegal_op;
                end
            end
            chk("vec_issue_cycle", got_issue, vecs[i].issue_t);
            chk("vec_done_cycle", got_done, vecs[i].done_t);
            chk("vec_illegal", got_ill, vecs[i].ill);
            tick();
        end

        // FIFO fill with the control FSM parked in s0.
        stall = 1;
        for (int k = 0; k < 5; k++) begin
            din = 16'h2000 + 16'(k); din_valid = 1'b1;
            tick();
            if (k == 3) chk("full_ready_low", din_ready, 0);
        end
        din_valid = 1'b0;
        chk("full_still_low", din_ready, 0);
        chk("full_head_issued", instr, 16'h2000);
        stall = 0;
        t = 0;
        issued.delete();
        if (new_instr) issued.push_back(instr);
        while (!done && t < 40) begin
            tick();
            t++;
        end
        chk("first_retire", done, 1);
        chk("ready_after_retire", din_ready, 1);
        t = 0;
        while ((q.size() > 0 || m_inflight) && t < 200) begin
            ww = instr;
            tick();
            t++;
            if (new_instr && instr != ww) issued.push_back(instr);
            else if (new_instr && issued.size() == 0) issued.push_back(instr);
        end
        chk("order_count", issued.size(), 4);
        for (int j = 0; j < 4 && j < issued.size(); j++)
            chk("issue_order", issued[j], 16'h2000 + 16'(j));

        // Single-step hold.
        hold = 1'b1; din = 16'hA111; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        repeat (4) tick();
        chk("hold_blocks", new_instr, 0);
        hold = 1'b0;
        tick();
        chk("hold_release", new_instr, 1);
        drain("hold_drain");

        // Hung execution, then reset while still executing.
        stuck = 1; din = 16'h4123; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        repeat (6) tick();
        chk("wdog_not_yet", wdog_err, 0);
        repeat (14) tick();
        chk("wdog_set", wdog_err, 1);
        repeat (5) tick();
        chk("wdog_sticky", wdog_err, 1);
        chk("busy_hung", busy, 1);
        async_reset();
        repeat (3) tick();
        chk("post_reset_idle", new_instr, 0);

        // Randomized traffic against the reference.
        for (int c = 0; c < 2500; c++) begin
            din_valid = ($urandom_range(0, 9) < 4);
            din       = 16'($urandom);
            hold      = ($urandom_range(0, 9) == 0);
            tick();
        end
        drain("random_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
